// File: rtl/pe_lane_mem_req_arbiter_if.sv
// Lane-side and memory-side bundle for the lane load/store concentrator.
// The DUT uses the slave modport; the environment driving the lanes and memory uses master.
interface pe_lane_mem_req_arbiter_if #(
  parameter int NUM_LANES      = 32,
  parameter int ADDR_W         = 24,
  parameter int DATA_W         = 32,
  parameter int TAG_FIFO_DEPTH = 8
);
  localparam int LANE_ID_W = $clog2(NUM_LANES);
  localparam int CNT_W     = $clog2(TAG_FIFO_DEPTH) + 1;

  logic [NUM_LANES-1:0]        lane_req_valid;
  logic [NUM_LANES-1:0]        lane_req_ready;
  logic [NUM_LANES-1:0]        lane_req_wr;
  logic [NUM_LANES*ADDR_W-1:0] lane_req_addr;
  logic [NUM_LANES*DATA_W-1:0] lane_req_data;
  logic                        mem_req_valid;
  logic                        mem_req_ready;
  logic                        mem_req_wr;
  logic [ADDR_W-1:0]           mem_req_addr;
  logic [DATA_W-1:0]           mem_req_data;
  logic [LANE_ID_W-1:0]        mem_req_lane;
  logic                        mem_rsp_valid;
  logic [DATA_W-1:0]           mem_rsp_data;
  logic [NUM_LANES-1:0]        lane_rsp_valid;
  logic [DATA_W-1:0]           lane_rsp_data;
  logic [CNT_W-1:0]            outstanding_rd;
  logic                        rsp_underflow_err;

  modport slave (
    input  lane_req_valid, lane_req_wr, lane_req_addr, lane_req_data,
           mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output lane_req_ready, mem_req_valid, mem_req_wr, mem_req_addr, mem_req_data,
           mem_req_lane, lane_rsp_valid, lane_rsp_data, outstanding_rd, rsp_underflow_err
  );

  modport master (
    output lane_req_valid, lane_req_wr, lane_req_addr, lane_req_data,
           mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  lane_req_ready, mem_req_valid, mem_req_wr, mem_req_addr, mem_req_data,
           mem_req_lane, lane_rsp_valid, lane_rsp_data, outstanding_rd, rsp_underflow_err
  );
endinterface

// File: rtl/pe_lane_mem_req_arbiter.sv
// N-lane request FIFOs -> round-robin -> one registered memory port; 2-cycle lane-to-mem latency.
// Lanes backpressured by FIFO full; loads also held back while the in-order read-tag FIFO is full.
module pe_lane_mem_req_arbiter #(
  parameter int NUM_LANES      = 32,
  parameter int ADDR_W         = 24,
  parameter int DATA_W         = 32,
  parameter int REQ_FIFO_DEPTH = 4,
  parameter int TAG_FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        reset_poedge,
  pe_lane_mem_req_arbiter_if.slave    bus
);
  localparam int LANE_ID_W = $clog2(NUM_LANES);
  localparam int RA        = $clog2(REQ_FIFO_DEPTH);
  localparam int TA        = $clog2(TAG_FIFO_DEPTH);

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  req_t                 head [NUM_LANES];
  logic [NUM_LANES-1:0] full, empty, push, pop, elig;
  logic                 tag_full, tag_empty, tag_push, tag_pop;
  logic [LANE_ID_W-1:0] tag_head;
  logic [TA:0]          tag_cnt;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    req_t            in_req;
    req_t            mem [REQ_FIFO_DEPTH];
    logic [RA-1:0]   wr_ptr, rd_ptr;
    logic [RA:0]     cnt;

    assign in_req = {bus.lane_req_wr[i], bus.lane_req_addr[i*ADDR_W +: ADDR_W],
                     bus.lane_req_data[i*DATA_W +: DATA_W]};
    // Ready ignores a same-cycle pop so a full FIFO never sees push and pop together.
    assign bus.lane_req_ready[i] = !full[i] && !reset_poedge;
    assign push[i]  = bus.lane_req_valid[i] && bus.lane_req_ready[i];
    assign full[i]  = (cnt == (RA+1)'(REQ_FIFO_DEPTH));
    assign empty[i] = (cnt == '0);
    assign head[i]  = mem[rd_ptr];
    assign elig[i]  = !empty[i] && (head[i].wr || !tag_full);

    always_ff @(posedge clk or posedge reset_poedge) begin
      if (reset_poedge) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push[i]) wr_ptr <= wr_ptr + 1'b1;
        if (pop[i])  rd_ptr <= rd_ptr + 1'b1;
        cnt <= cnt + (RA+1)'(push[i]) - (RA+1)'(pop[i]);
      end
    end

    always_ff @(posedge clk) begin
      if (push[i]) mem[wr_ptr] <= in_req;
    end
  end

  logic [LANE_ID_W-1:0] rr_ptr, gnt_idx, out_lane;
  logic                 gnt_found, grant, out_vld;
  req_t                 gnt_req, out_req;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (!gnt_found && elig[LANE_ID_W'((int'(rr_ptr) + k) % NUM_LANES)]) begin
        gnt_found = 1'b1;
        gnt_idx   = LANE_ID_W'((int'(rr_ptr) + k) % NUM_LANES);
      end
    end
  end

  assign grant   = gnt_found && (!out_vld || bus.mem_req_ready);
  assign gnt_req = head[gnt_idx];

  always_comb begin
    pop          = '0;
    pop[gnt_idx] = grant;
  end

  always_ff @(posedge clk or posedge reset_poedge) begin
    if (reset_poedge) begin
      out_vld  <= 1'b0;
      out_req  <= '0;
      out_lane <= '0;
      rr_ptr   <= '0;
    end else if (grant) begin
      out_vld  <= 1'b1;
      out_req  <= gnt_req;
      out_lane <= gnt_idx;
      rr_ptr   <= (gnt_idx == LANE_ID_W'(NUM_LANES-1)) ? '0 : gnt_idx + 1'b1;
    end else if (bus.mem_req_ready) begin
      out_vld  <= 1'b0;
    end
  end

  assign bus.mem_req_valid = out_vld;
  assign bus.mem_req_wr    = out_req.wr;
  assign bus.mem_req_addr  = out_req.addr;
  assign bus.mem_req_data  = out_req.data;
  assign bus.mem_req_lane  = out_lane;

  // Read tags: lane ids of issued loads, in issue order, matched to in-order responses.
  logic [LANE_ID_W-1:0] tag_mem [TAG_FIFO_DEPTH];
  logic [TA-1:0]        tag_wr_ptr, tag_rd_ptr;

  assign tag_push  = grant && !gnt_req.wr;
  assign tag_pop   = bus.mem_rsp_valid && !tag_empty;
  assign tag_full  = (tag_cnt == (TA+1)'(TAG_FIFO_DEPTH));
  assign tag_empty = (tag_cnt == '0);
  assign tag_head  = tag_mem[tag_rd_ptr];

  always_ff @(posedge clk or posedge reset_poedge) begin
    if (reset_poedge) begin
      tag_wr_ptr <= '0;
      tag_rd_ptr <= '0;
      tag_cnt    <= '0;
    end else begin
      if (tag_push) tag_wr_ptr <= tag_wr_ptr + 1'b1;
      if (tag_pop)  tag_rd_ptr <= tag_rd_ptr + 1'b1;
      tag_cnt <= tag_cnt + (TA+1)'(tag_push) - (TA+1)'(tag_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (tag_push) tag_mem[tag_wr_ptr] <= gnt_idx;
  end

  logic [NUM_LANES-1:0] rsp_vld;
  logic [DATA_W-1:0]    rsp_dat;
  logic                 underflow;

  always_ff @(posedge clk or posedge reset_poedge) begin
    if (reset_poedge) begin
      rsp_vld   <= '0;
      rsp_dat   <= '0;
      underflow <= 1'b0;
    end else begin
      rsp_vld <= tag_pop ? ({{(NUM_LANES-1){1'b0}}, 1'b1} << tag_head) : '0;
      if (tag_pop) rsp_dat <= bus.mem_rsp_data;
      if (bus.mem_rsp_valid && tag_empty) underflow <= 1'b1;
    end
  end

  assign bus.lane_rsp_valid    = rsp_vld;
  assign bus.lane_rsp_data     = rsp_dat;
  assign bus.outstanding_rd    = tag_cnt;
  assign bus.rsp_underflow_err = underflow;
endmodule

// File: tb/tb_pe_lane_mem_req_arbiter.sv
// Directed bench for the lane load/store concentrator: reset, latency, round-robin,
// stall/backpressure, tag-FIFO limit, response steering, underflow and mid-burst reset.
module tb_pe_lane_mem_req_arbiter;
  localparam int NL = 32, AW = 24, DW = 32, RD = 4, TD = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pe_lane_mem_req_arbiter_if #(.NUM_LANES(NL), .ADDR_W(AW), .DATA_W(DW), .TAG_FIFO_DEPTH(TD)) bus ();

  pe_lane_mem_req_arbiter #(
    .NUM_LANES(NL), .ADDR_W(AW), .DATA_W(DW), .REQ_FIFO_DEPTH(RD), .TAG_FIFO_DEPTH(TD)
  ) u_dut (
    .clk          (clk),
    .reset_poedge (rst),
    .bus          (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int l, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.lane_req_valid[l]          = 1'b1;
    bus.lane_req_wr[l]             = wr;
    bus.lane_req_addr[l*AW +: AW]  = a;
    bus.lane_req_data[l*DW +: DW]  = d;
  endtask

  task automatic clr_req();
    bus.lane_req_valid = '0;
  endtask

  int order4 [8] = '{6, 7, 8, 0, 1, 2, 3, 4};
  int drain4 [8] = '{7, 8, 0, 1, 2, 3, 4, 5};

  initial begin
    rst                = 1'b1;
    bus.lane_req_valid = '0;
    bus.lane_req_wr    = '0;
    bus.lane_req_addr  = '0;
    bus.lane_req_data  = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_rsp_valid  = 1'b0;
    bus.mem_rsp_data   = '0;
    repeat (2) tick();

    // Reset state
    chk("rst_lane_req_ready", bus.lane_req_ready, 0);
    chk("rst_mem_req_valid", bus.mem_req_valid, 0);
    chk("rst_lane_rsp_valid", bus.lane_rsp_valid, 0);
    chk("rst_lane_rsp_data", bus.lane_rsp_data, 0);
    chk("rst_outstanding", bus.outstanding_rd, 0);
    chk("rst_underflow", bus.rsp_underflow_err, 0);
    rst = 1'b0;
    tick();
    chk("ready_after_rst", bus.lane_req_ready, 64'hFFFF_FFFF);

    // All lanes push one store at once: grants 0..31 back-to-back
    bus.mem_req_ready = 1'b1;
    for (int l = 0; l < NL; l++) set_req(l, 1'b1, AW'(l * 16), 32'hA000_0000 + 32'(l));
    tick();
    clr_req();
    chk("t2_first_latency", bus.mem_req_valid, 0);
    for (int i = 0; i < NL; i++) begin
      tick();
      chk("t2_valid", bus.mem_req_valid, 1);
      chk("t2_lane", bus.mem_req_lane, 64'(i));
      chk("t2_data", bus.mem_req_data, 32'hA000_0000 + 32'(i));
    end
    tick();
    chk("t2_idle", bus.mem_req_valid, 0);

    // rr_ptr wrapped to 0: lanes 0,1 come out 0 then 1 (rr -> 2)
    set_req(1, 1'b1, 24'h000011, 32'h11);
    set_req(0, 1'b1, 24'h000010, 32'h10);
    tick();
    clr_req();
    tick();
    chk("rr_wrap_first", bus.mem_req_lane, 0);
    tick();
    chk("rr_wrap_second", bus.mem_req_lane, 1);
    // From rr_ptr=2, lane 5 beats lane 0 (rr -> 1)
    set_req(0, 1'b1, 24'h000020, 32'h20);
    set_req(5, 1'b1, 24'h000050, 32'h50);
    tick();
    clr_req();
    tick();
    chk("rr_order_first", bus.mem_req_lane, 5);
    tick();
    chk("rr_order_second", bus.mem_req_lane, 0);
    tick();

    // Single lane 3 load, response steered back one cycle later (rr -> 4)
    set_req(3, 1'b0, 24'h000100, 32'h0);
    tick();
    clr_req();
    chk("t1_e0_valid", bus.mem_req_valid, 0);
    tick();
    chk("t1_valid", bus.mem_req_valid, 1);
    chk("t1_lane", bus.mem_req_lane, 3);
    chk("t1_wr", bus.mem_req_wr, 0);
    chk("t1_addr", bus.mem_req_addr, 24'h000100);
    chk("t1_outstanding", bus.outstanding_rd, 1);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'hDEAD_BEEF;
    tick();
    bus.mem_rsp_valid = 1'b0;
    chk("t1_rsp_valid", bus.lane_rsp_valid, 64'h8);
    chk("t1_rsp_data", bus.lane_rsp_data, 32'hDEAD_BEEF);
    chk("t1_outstanding0", bus.outstanding_rd, 0);
    chk("t1_drained", bus.mem_req_valid, 0);
    tick();
    chk("t1_rsp_pulse", bus.lane_rsp_valid, 0);
    chk("t1_rsp_data_hold", bus.lane_rsp_data, 32'hDEAD_BEEF);

    // Stall: lane 6 parked in output register, lane 5 fills its 4-deep FIFO
    bus.mem_req_ready = 1'b0;
    set_req(6, 1'b1, 24'h000600, 32'h66);
    tick();
    clr_req();
    tick();
    chk("t3_park_lane", bus.mem_req_lane, 6);
    for (int k = 0; k < 4; k++) begin
      set_req(5, 1'b1, 24'h000500 + 24'(k), 32'(k));
      chk("t3_ready_before_full", bus.lane_req_ready[5], 1);
      tick();
    end
    set_req(5, 1'b1, 24'h000504, 32'h4);
    chk("t3_ready_full", bus.lane_req_ready[5], 0);
    tick();
    chk("t3_ready_still_full", bus.lane_req_ready[5], 0);
    chk("t3_stall_valid", bus.mem_req_valid, 1);
    chk("t3_stall_addr", bus.mem_req_addr, 24'h000600);
    chk("t3_stall_data", bus.mem_req_data, 32'h66);
    bus.mem_req_ready = 1'b1;
    tick();
    chk("t3_drain0", bus.mem_req_addr, 24'h000500);
    chk("t3_ready_reopen", bus.lane_req_ready[5], 1);
    tick();
    clr_req();
    for (int k = 1; k < 5; k++) begin
      chk("t3_drain_addr", bus.mem_req_addr, 24'h000500 + 24'(k));
      chk("t3_drain_lane", bus.mem_req_lane, 5);
      tick();
    end
    chk("t3_idle", bus.mem_req_valid, 0);

    // Tag FIFO limit: 9 loads from lanes 0..8 (rr=6), the 9th is held back
    for (int l = 0; l < 9; l++) set_req(l, 1'b0, 24'h001000 + 24'(l), 32'h0);
    tick();
    clr_req();
    for (int j = 0; j < 8; j++) begin
      tick();
      chk("t4_lane", bus.mem_req_lane, 64'(order4[j]));
      chk("t4_wr", bus.mem_req_wr, 0);
    end
    tick();
    chk("t4_blocked", bus.mem_req_valid, 0);
    chk("t4_outstanding8", bus.outstanding_rd, 8);
    set_req(9, 1'b1, 24'h000900, 32'h99);
    tick();
    clr_req();
    tick();
    chk("t4_store_valid", bus.mem_req_valid, 1);
    chk("t4_store_lane", bus.mem_req_lane, 9);
    tick();
    chk("t4_still_blocked", bus.mem_req_valid, 0);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'h5151_0006;
    tick();
    bus.mem_rsp_valid = 1'b0;
    chk("t4_rsp_lane6", bus.lane_rsp_valid, 64'd1 << 6);
    chk("t4_outstanding7", bus.outstanding_rd, 7);
    chk("t4_no_same_cycle_credit", bus.mem_req_valid, 0);
    tick();
    chk("t4_ninth_valid", bus.mem_req_valid, 1);
    chk("t4_ninth_lane", bus.mem_req_lane, 5);
    chk("t4_ninth_addr", bus.mem_req_addr, 24'h001005);
    chk("t4_outstanding8b", bus.outstanding_rd, 8);
    for (int j = 0; j < 8; j++) begin
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = 32'hC0DE_0000 + 32'(j);
      tick();
      chk("t4_drain_valid", bus.lane_rsp_valid, 64'd1 << drain4[j]);
      chk("t4_drain_data", bus.lane_rsp_data, 32'hC0DE_0000 + 32'(j));
    end
    bus.mem_rsp_valid = 1'b0;
    chk("t4_outstanding0", bus.outstanding_rd, 0);
    tick();
    chk("t4_rsp_idle", bus.lane_rsp_valid, 0);

    // Interleaved lanes 2,7,2 with a same-cycle tag push and pop
    set_req(2, 1'b0, 24'h000200, 32'h0);
    tick();
    clr_req();
    tick();
    chk("t5_lane2_issue", bus.mem_req_lane, 2);
    chk("t5_outstanding1", bus.outstanding_rd, 1);
    set_req(7, 1'b0, 24'h000700, 32'h0);
    tick();
    clr_req();
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'hAAAA_0001;
    tick();
    bus.mem_rsp_valid = 1'b0;
    chk("t5_rsp_a", bus.lane_rsp_valid, 64'h4);
    chk("t5_data_a", bus.lane_rsp_data, 32'hAAAA_0001);
    chk("t5_lane7_issue", bus.mem_req_lane, 7);
    chk("t5_push_pop_count", bus.outstanding_rd, 1);
    set_req(2, 1'b0, 24'h000204, 32'h0);
    tick();
    clr_req();
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'hBBBB_0002;
    tick();
    bus.mem_rsp_valid = 1'b0;
    chk("t5_rsp_b", bus.lane_rsp_valid, 64'h80);
    chk("t5_data_b", bus.lane_rsp_data, 32'hBBBB_0002);
    chk("t5_lane2b_addr", bus.mem_req_addr, 24'h000204);
    chk("t5_push_pop_count2", bus.outstanding_rd, 1);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'hCCCC_0003;
    tick();
    bus.mem_rsp_valid = 1'b0;
    chk("t5_rsp_c", bus.lane_rsp_valid, 64'h4);
    chk("t5_data_c", bus.lane_rsp_data, 32'hCCCC_0003);
    chk("t5_outstanding0", bus.outstanding_rd, 0);
    tick();
    chk("t5_rsp_idle", bus.lane_rsp_valid, 0);
    chk("t5_data_hold", bus.lane_rsp_data, 32'hCCCC_0003);

    // Response with nothing outstanding
    chk("t6_err_before", bus.rsp_underflow_err, 0);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'h0000_0099;
    tick();
    bus.mem_rsp_valid = 1'b0;
    chk("t6_err_set", bus.rsp_underflow_err, 1);
    chk("t6_no_rsp", bus.lane_rsp_valid, 0);
    chk("t6_data_kept", bus.lane_rsp_data, 32'hCCCC_0003);
    tick();
    chk("t6_err_sticky", bus.rsp_underflow_err, 1);

    // Reset mid-burst (rr=3: lane 3 load sits in the output register)
    bus.mem_req_ready = 1'b0;
    for (int l = 0; l < 4; l++) set_req(l, 1'b0, 24'h003000 + 24'(l), 32'h0);
    tick();
    clr_req();
    tick();
    chk("t6_burst_lane", bus.mem_req_lane, 3);
    chk("t6_burst_outstanding", bus.outstanding_rd, 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", bus.mem_req_valid, 0);
    chk("t6_rst_ready", bus.lane_req_ready, 0);
    chk("t6_rst_outstanding", bus.outstanding_rd, 0);
    chk("t6_rst_err", bus.rsp_underflow_err, 0);
    chk("t6_rst_rsp_data", bus.lane_rsp_data, 0);
    chk("t6_rst_addr", bus.mem_req_addr, 0);
    tick();
    rst = 1'b0;
    bus.mem_req_ready = 1'b1;
    tick();
    chk("t6_post_ready", bus.lane_req_ready, 64'hFFFF_FFFF);
    chk("t6_post_valid", bus.mem_req_valid, 0);
    tick();
    chk("t6_fifos_empty", bus.mem_req_valid, 0);
    chk("t6_post_outstanding", bus.outstanding_rd, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
